// File: rtl/axis_stream_checker_pkg.sv
// Shared definitions for the AXI4-Stream checker: FSM states and saturating increment.
package axis_stream_checker_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StGap
  } state_e;

  // Counters are at most this wide; the helper works on a common 32-bit container.
  localparam int unsigned MaxCntWidth = 32;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [MaxCntWidth-1:0] sat_inc(input logic [MaxCntWidth-1:0] val,
                                                     input int unsigned width);
    logic [MaxCntWidth-1:0] max_val;
    if (width >= MaxCntWidth) begin
      max_val = '1;
    end else begin
      max_val = (MaxCntWidth'(1) << width) - MaxCntWidth'(1);
    end
    return (val >= max_val) ? max_val : val + MaxCntWidth'(1);
  endfunction

endpackage

// File: rtl/axis_stream_checker_if.sv
// AXI4-Stream beat channel between a master and the checker.
interface axis_stream_checker_if #(
  parameter int unsigned DATA_SIZE = 32
);
  logic [DATA_SIZE-1:0]   tdata;
  logic [DATA_SIZE/8-1:0] tstrb;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at its maximum value.
module axis_sat_counter
  import axis_stream_checker_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [MaxCntWidth-1:0] cnt_inc;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_inc = sat_inc(MaxCntWidth'(cnt_q), CNT_WIDTH);
    cnt_d   = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_inc[CNT_WIDTH-1:0];
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/axis_stream_checker.sv
// AXI4-Stream sink that checks an incrementing data pattern, tstrb and tlast framing,
// counts packets/errors and inserts back-pressure gaps after every packet boundary.
module axis_stream_checker
  import axis_stream_checker_pkg::*;
#(
  parameter int unsigned         DATA_SIZE  = 32,
  parameter int unsigned         PKT_LEN    = 16,
  parameter logic [DATA_SIZE-1:0] SEED      = '0,
  parameter int unsigned         GAP_CYCLES = 2,
  parameter int unsigned         CNT_WIDTH  = 16
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_aresetn,
  input  logic                  s00_axis_enable,
  input  logic                  s00_axis_clear,
  axis_stream_checker_if.slave  s00_axis,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  data_err_count,
  output logic [CNT_WIDTH-1:0]  last_err_count,
  output logic                  err_flag,
  output logic [DATA_SIZE-1:0]  expected_data
);

  localparam int unsigned StrbW  = DATA_SIZE / 8;
  localparam int unsigned IdxW   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GapMax = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [StrbW-1:0]     StrbAllOnes = {StrbW{1'b1}};
  localparam logic [IdxW-1:0]      LastIdx     = IdxW'(PKT_LEN - 1);
  localparam logic [GapW-1:0]      GapLast     = GapW'(GapMax);
  localparam logic [DATA_SIZE-1:0] DataOne     = DATA_SIZE'(1);

  state_e                 state_q, state_d;
  logic                   tready_q, tready_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_SIZE-1:0]   expected_q, expected_d;
  logic                   err_q, err_d;

  logic beat, data_bad, last_bad, at_last, boundary;

  // Beat checks and data-path next state; a clear in the same cycle drops the beat.
  always_comb begin
    beat     = s00_axis.tvalid && tready_q && !s00_axis_clear;
    at_last  = (idx_q == LastIdx);
    data_bad = beat && ((s00_axis.tdata != expected_q) || (s00_axis.tstrb != StrbAllOnes));
    last_bad = beat && (s00_axis.tlast != at_last);
    boundary = beat && (s00_axis.tlast || at_last);

    idx_d      = idx_q;
    expected_d = expected_q;
    err_d      = err_q | data_bad | last_bad;
    if (s00_axis_clear) begin
      idx_d      = '0;
      expected_d = SEED;
      err_d      = 1'b0;
    end else if (beat) begin
      idx_d      = boundary ? '0 : idx_q + IdxW'(1);
      // Resync on the received value so one bad beat is counted once.
      expected_d = s00_axis.tdata + DataOne;
    end
  end

  // Ready FSM: a packet boundary takes priority over a concurrent pause request.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (s00_axis_enable) begin
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (boundary && (GAP_CYCLES > 0)) begin
          state_d = StGap;
          gap_d   = '0;
        end else if (!s00_axis_enable) begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = s00_axis_enable ? StRecv : StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    tready_d = (state_d == StRecv);
  end

  // State, ready and data-path registers with synchronous active-low reset.
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state_q    <= StIdle;
      tready_q   <= 1'b0;
      gap_q      <= '0;
      idx_q      <= '0;
      expected_q <= SEED;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tready_q   <= tready_d;
      gap_q      <= gap_d;
      idx_q      <= idx_d;
      expected_q <= expected_d;
      err_q      <= err_d;
    end
  end

  axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pkt_cnt (
    .clk_i  (s00_axis_aclk),
    .rst_ni (s00_axis_aresetn),
    .clr_i  (s00_axis_clear),
    .inc_i  (boundary),
    .cnt_o  (pkt_count)
  );

  axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_data_err_cnt (
    .clk_i  (s00_axis_aclk),
    .rst_ni (s00_axis_aresetn),
    .clr_i  (s00_axis_clear),
    .inc_i  (data_bad),
    .cnt_o  (data_err_count)
  );

  axis_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_last_err_cnt (
    .clk_i  (s00_axis_aclk),
    .rst_ni (s00_axis_aresetn),
    .clr_i  (s00_axis_clear),
    .inc_i  (last_bad),
    .cnt_o  (last_err_count)
  );

  assign s00_axis.tready = tready_q;
  assign err_flag        = err_q;
  assign expected_data   = expected_q;

endmodule
